// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised load/shift/rotate register with an autonomous LSB-first frame serialiser.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             par_in,
  input  logic                         ser_in_msb,
  input  logic                         ser_in_lsb,
  input  logic                         start,
  output logic [WIDTH-1:0]             out,
  output logic                         ser_out_lsb,
  output logic                         ser_out_msb,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] out_n;
  logic [CW-1:0] cnt_n;
  logic done_n;
  assign ser_out_lsb = out[0];
  assign ser_out_msb = out[WIDTH-1];
  assign busy = (state == SHIFT);
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state <= IDLE;
      out <= RESET_VALUE;
      bit_cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      out <= out_n;
      bit_cnt <= cnt_n;
      done <= done_n;
    end
  // the final frame shift drains the last bit and leaves the register zeroed
  always_comb begin
    state_n = state;
    out_n = out;
    cnt_n = bit_cnt;
    done_n = done;
    if (enable) begin
      done_n = 1'b0;
      if (state == SHIFT) begin
        out_n = {1'b0, out[WIDTH-1:1]};
        cnt_n = bit_cnt + CW'(1);
        if (bit_cnt == LAST) begin
          out_n = '0;
          cnt_n = '0;
          state_n = IDLE;
          done_n = 1'b1;
        end
      end else if (start) begin
        out_n = par_in;
        cnt_n = '0;
        state_n = SHIFT;
      end else begin
        case (mode)
          3'b001: out_n = par_in;
          3'b010: out_n = {ser_in_msb, out[WIDTH-1:1]};
          3'b011: out_n = {out[WIDTH-2:0], ser_in_lsb};
          3'b100: out_n = {out[0], out[WIDTH-1:1]};
          3'b101: out_n = {out[WIDTH-2:0], out[WIDTH-1]};
          3'b111: out_n = RESET_VALUE;
          default: out_n = out;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: three widths driven in lockstep, scoreboard-checked against a word-level model.
module tb_universal_shift_reg;
  logic clk = 1'b0;
  logic clear = 1'b1, enable = 1'b0, start = 1'b0, sm = 1'b0, sl = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [31:0] pi = 32'd0;
  logic [3:0] o4; logic [2:0] c4; logic b4, d4, lsb4, msb4;
  logic [7:0] o8; logic [3:0] c8; logic b8, d8, lsb8, msb8;
  logic [1:0] o2; logic [1:0] c2; logic b2, d2, lsb2, msb2;
  int checks = 0, failures = 0;
  logic mon_on = 1'b0;
  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4), .RESET_VALUE(4'h0)) u4 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .par_in(pi[3:0]),
    .ser_in_msb(sm), .ser_in_lsb(sl), .start(start), .out(o4), .ser_out_lsb(lsb4),
    .ser_out_msb(msb4), .busy(b4), .done(d4), .bit_cnt(c4));
  universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .par_in(pi[7:0]),
    .ser_in_msb(sm), .ser_in_lsb(sl), .start(start), .out(o8), .ser_out_lsb(lsb8),
    .ser_out_msb(msb8), .busy(b8), .done(d8), .bit_cnt(c8));
  universal_shift_reg #(.WIDTH(2), .RESET_VALUE(2'b10)) u2 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .par_in(pi[1:0]),
    .ser_in_msb(sm), .ser_in_lsb(sl), .start(start), .out(o2), .ser_out_lsb(lsb2),
    .ser_out_msb(msb2), .busy(b2), .done(d2), .bit_cnt(c2));

  typedef struct packed {logic [31:0] o; logic b; logic d; logic [7:0] c;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  int wd[3] = '{4, 8, 2};
  logic [31:0] rv[3] = '{32'h0, 32'hA5, 32'h2};
  logic [31:0] r[3], word[3];
  logic bz[3], dn[3];
  int k[3];

  function automatic logic [31:0] msk(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic void reset_models();
    for (int d = 0; d < 3; d++) begin
      r[d] = rv[d]; word[d] = 0; bz[d] = 0; dn[d] = 0; k[d] = 0;
    end
  endfunction

  // a frame is modelled as the loaded word viewed through a right shift by the bit index
  function automatic void step(int d, logic en, logic st, logic [2:0] md, logic [31:0] p, logic s_m, logic s_l);
    int w = wd[d];
    logic [31:0] m = msk(w);
    logic [31:0] x = r[d];
    if (!en) return;
    dn[d] = 0;
    if (bz[d]) begin
      k[d]++;
      if (k[d] == w) begin bz[d] = 0; k[d] = 0; r[d] = 0; dn[d] = 1; end
    end else if (st) begin
      word[d] = p & m; bz[d] = 1; k[d] = 0;
    end else begin
      case (md)
        3'd1: r[d] = p & m;
        3'd2: r[d] = (x >> 1) | (32'(s_m) << (w - 1));
        3'd3: r[d] = ((x << 1) | 32'(s_l)) & m;
        3'd4: r[d] = (x >> 1) | ((x & 32'd1) << (w - 1));
        3'd5: r[d] = ((x << 1) | (x >> (w - 1))) & m;
        3'd7: r[d] = rv[d];
        default: r[d] = x;
      endcase
    end
  endfunction

  function automatic void push_all();
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      e.o = bz[d] ? (word[d] >> k[d]) : r[d];
      e.b = bz[d];
      e.d = dn[d];
      e.c = bz[d] ? 8'(k[d]) : 8'd0;
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endfunction

  task automatic cyc(input logic en, input logic st, input logic [2:0] md, input logic [31:0] p,
                     input logic s_m, input logic s_l);
    @(negedge clk);
    clear = 0; enable = en; start = st; mode = md; pi = p; sm = s_m; sl = s_l;
    for (int d = 0; d < 3; d++) step(d, en, st, md, p, s_m, s_l);
    push_all();
  endtask

  task automatic do_clear();
    @(negedge clk);
    #2;
    if (!clear) begin
      clear = 1;
      reset_models();
      push_all();
    end
    push_all();
  endtask

  task automatic chk(input string nm, input int w, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s w=%0d t=%0t actual=%h required=%h", nm, w, $time, a, e);
    end
  endtask

  task automatic check_dut(input int d);
    exp_t e;
    logic [31:0] ao;
    logic [7:0] ac;
    logic ab, ad, al, am;
    int w = wd[d];
    case (d)
      0: begin ao = 32'(o4); ab = b4; ad = d4; ac = 8'(c4); al = lsb4; am = msb4; end
      1: begin ao = 32'(o8); ab = b8; ad = d8; ac = 8'(c8); al = lsb8; am = msb8; end
      default: begin ao = 32'(o2); ab = b2; ad = d2; ac = 8'(c2); al = lsb2; am = msb2; end
    endcase
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
      checks++; failures++;
      $display("FAIL sb_underflow w=%0d t=%0t actual=empty required=entry", w, $time);
      return;
    end
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk("out", w, ao, e.o);
    chk("busy", w, 32'(ab), 32'(e.b));
    chk("done", w, 32'(ad), 32'(e.d));
    chk("bit_cnt", w, 32'(ac), 32'(e.c));
    chk("ser_out_lsb", w, 32'(al), 32'(e.o[0]));
    chk("ser_out_msb", w, 32'(am), 32'(e.o[w-1]));
  endtask

  initial forever begin
    @(posedge clk or posedge clear);
    #1;
    if (mon_on) for (int d = 0; d < 3; d++) check_dut(d);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_on = 1;
    reset_models();
    push_all();
    do_clear();
    cyc(1, 0, 3'd1, 32'h6, 0, 0);
    repeat (3) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    cyc(1, 0, 3'd1, 32'hB, 0, 0);
    cyc(1, 0, 3'd2, 32'h0, 1, 0);
    cyc(1, 0, 3'd3, 32'h0, 0, 0);
    cyc(1, 0, 3'd4, 32'h0, 0, 0);
    cyc(1, 0, 3'd5, 32'h0, 0, 0);
    cyc(1, 0, 3'd7, 32'h0, 0, 0);
    cyc(1, 1, 3'd1, 32'hE, 0, 0);
    repeat (6) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    cyc(1, 1, 3'd1, 32'hE, 0, 0);
    cyc(1, 0, 3'd0, 32'h0, 0, 0);
    cyc(0, 1, 3'd1, 32'h5, 0, 0);
    cyc(0, 0, 3'd1, 32'h5, 0, 0);
    cyc(1, 0, 3'd1, 32'h5, 0, 0);
    cyc(1, 1, 3'd1, 32'h5, 0, 0);
    repeat (8) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    cyc(1, 1, 3'd0, 32'hD7, 0, 0);
    repeat (2) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    do_clear();
    cyc(1, 1, 3'd0, 32'h9C, 0, 0);
    repeat (10) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    foreach (wd[i]) begin
      cyc(1, 1, 3'd0, 32'hC9, 0, 0);
      repeat (wd[i]) cyc(1, 0, 3'd0, 32'h0, 0, 0);
      cyc(1, 1, 3'd0, 32'h36, 0, 0);
      repeat (wd[i] + 2) cyc(1, 0, 3'd0, 32'h0, 0, 0);
    end
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) do_clear();
      else cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
               $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    mon_on = 0;
    chk("sb_drain", 0, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal register: parallel load, hold, logical shift and rotate in both directions, plus an autonomous parallel-in/serial-out frame mode with busy/done handshake. It generalises the team's 4-bit PIPO register in width and mode. It is the common storage/serialiser element for the sequential library, used standalone or ahead of serial links.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value of `out` after `clear` or a synchronous clear (WIDTH bits).
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset. It is the only reset.
- enable  in  1  clock enable. When low, all state freezes, including the frame FSM and counter.
- mode  in  3  operation select; see Operation. Ignored while `busy`.
- par_in  in  WIDTH  parallel load data.
- ser_in_msb  in  1  serial data entering bit WIDTH-1 on a right shift.
- ser_in_lsb  in  1  serial data entering bit 0 on a left shift.
- start  in  1  begin a frame transmission. Sampled only when idle and `enable`=1.
- out  out  WIDTH  register contents.
- ser_out_lsb  out  1  equals `out[0]`; this is the frame serial output.
- ser_out_msb  out  1  equals `out[WIDTH-1]`.
- busy  out  1  high while a frame is being shifted.
- done  out  1  one-cycle pulse after the last frame bit.
- bit_cnt  out  $clog2(WIDTH+1)  index of the frame bit currently on `ser_out_lsb`. Reads 0 when idle.

## Operation
- FSM has two states.
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1.
- On `clear`=1: `out`=RESET_VALUE, FSM=IDLE, `bit_cnt`=0, `done`=0. This applies immediately, takes effect mid-frame, and aborts the frame with no `done` pulse.
- With `enable`=0, every register holds, including `done`. A pending `done` pulse is stretched until the next enabled edge.
- In IDLE with `enable`=1 and `start`=0, `mode` decodes as follows:
  - 000 hold.
  - 001 load `par_in`.
  - 010 shift right: `out` = {ser_in_msb, out[WIDTH-1:1]}.
  - 011 shift left: `out` = {out[WIDTH-2:0], ser_in_lsb}.
  - 100 rotate right by 1.
  - 101 rotate left by 1.
  - 110 hold (reserved).
  - 111 synchronous clear to RESET_VALUE.
- In IDLE with `enable`=1 and `start`=1, `start` overrides `mode`:
  - load `par_in`;
  - go to SHIFT;
  - `bit_cnt`=0.
- In SHIFT with `enable`=1:
  - Shift right with 0 filling the MSB, and increment `bit_cnt`.
  - When `bit_cnt`=WIDTH-1 at the edge, perform the final shift instead. `out` becomes all zeros, FSM goes to IDLE, `bit_cnt`=0, and `done`=1 for the following cycle.
- `start` and `mode` are ignored in SHIFT, so a re-trigger is not possible.
- `done` is cleared on the next enabled edge. If that edge also accepts `start`, `done` falls while `busy` rises.
- Shift and rotate amounts are always exactly 1 bit. There are no widening or truncation effects.

## Timing
- All outputs are registered except `ser_out_lsb` and `ser_out_msb`, which are direct wires from `out`.
- Load, shift, rotate and synchronous clear have a latency of 1 edge.
- Frame latency is measured from the start edge T, assuming `enable` stays high:
  - bit k of the loaded word is on `ser_out_lsb` and `bit_cnt`=k during the cycle after edge T+k, for k = 0..WIDTH-1;
  - `busy` is high for exactly WIDTH cycles;
  - `done` is high for the single cycle after edge T+WIDTH.
- The earliest next `start` accepted is at edge T+WIDTH+1, which gives back-to-back frames with a 1-cycle gap.
- Each `enable`-low cycle inside a frame stretches the frame by exactly one cycle, with the bit held on `ser_out_lsb`.
- Async `clear` deassertion is synchronised externally by the user. The block needs no recovery cycle beyond the first edge.

## Test plan
- Reset and load (WIDTH=4):
  - assert `clear`, which requires `out`=0000, `busy`=0, `done`=0;
  - release `clear` and apply mode 001 with `par_in`=0110, which gives `out`=0110 after 1 edge;
  - apply mode 000 for 3 edges, and `out` must stay 0110.
- Shift and rotate (WIDTH=4), starting from `out`=1011:
  - mode 010 with `ser_in_msb`=1 → 1101;
  - mode 011 with `ser_in_lsb`=0 → 1010;
  - mode 100 → 0101;
  - mode 101 → 1010;
  - mode 111 → RESET_VALUE.
- Frame (WIDTH=4): pulse `start` with `par_in`=1110 and `mode`=001.
  - `ser_out_lsb` must show 0,1,1,1 on consecutive cycles with `bit_cnt` 0..3;
  - `busy` must be high for 4 cycles;
  - `done` must pulse once;
  - `out` must end at 0000.
- Stall: same frame with `enable` low for 2 cycles while `bit_cnt`=1.
  - bit 1 is held for 3 cycles;
  - `busy` lasts 6 cycles;
  - `mode`=001 and `start` toggled while busy have no effect.
- Abort: assert `clear` while `bit_cnt`=2.
  - `out`=RESET_VALUE, `busy`=0 and `bit_cnt`=0 immediately, with no `done` pulse;
  - after release, a new `start` yields a complete frame.
- Back-to-back: assert `start` in the cycle `done`=1.
  - `done` falls and `busy` rises on the same edge;
  - the second frame bits are correct;
  - repeat with WIDTH=8 and WIDTH=2 to cover the counter boundary.
